// File: rtl/tx_pkg.sv
// Shared state encoding and burst/counter sizing for the TX fire controller.
// Default sizing matches 16 channels, 8-bit delays, 2 periods of 4+4 clk.
package tx_pkg;

    localparam int NUM_CHANNELS_DEF = 16;
    localparam int DELAY_WIDTH_DEF  = 8;
    localparam int HALF_PERIOD_DEF  = 4;
    localparam int NUM_CYCLES_DEF   = 2;

    function automatic int burst_len(input int hp, input int nc);
        return 2 * hp * nc;
    endfunction

    function automatic int dmax_of(input int dw);
        return (1 << dw) - 1;
    endfunction

    // One spare bit over DMAX+BURST so the fire counter never wraps.
    function automatic int t_width(input int dw, input int hp, input int nc);
        return dw + $clog2(2 * hp * nc) + 1;
    endfunction

    localparam int BURST   = burst_len(HALF_PERIOD_DEF, NUM_CYCLES_DEF);
    localparam int DMAX    = dmax_of(DELAY_WIDTH_DEF);
    localparam int T_WIDTH = t_width(DELAY_WIDTH_DEF, HALF_PERIOD_DEF, NUM_CYCLES_DEF);

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_REQ   = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_NEXT  = 3'd3;
    localparam state_t S_ARMED = 3'd4;
    localparam state_t S_FIRE  = 3'd5;
    localparam state_t S_FIN   = 3'd6;

endpackage

// File: rtl/tx_pulse_gen.sv
// One channel's bipolar burst: window compare of t against this channel's delay.
// Registered outputs, one cycle after t; no backpressure.
module tx_pulse_gen
    import tx_pkg::*;
#(
    parameter int DELAY_WIDTH = DELAY_WIDTH_DEF,
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int NUM_CYCLES  = NUM_CYCLES_DEF,
    parameter int T_W         = t_width(DELAY_WIDTH, HALF_PERIOD, NUM_CYCLES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_en,
    input  logic [T_W-1:0]         i_t,
    input  logic [DELAY_WIDTH-1:0] i_delay,
    output logic                   o_tx_p,
    output logic                   o_tx_n
);

    localparam int BURST_L = burst_len(HALF_PERIOD, NUM_CYCLES);
    localparam int PERIOD  = 2 * HALF_PERIOD;

    logic [T_W-1:0] w_delay_ext;
    logic [T_W-1:0] w_r;
    logic [T_W-1:0] w_phase;
    logic           w_started;
    logic           w_active;
    logic           w_p_phase;
    logic           r_tx_p;
    logic           r_tx_n;

    assign w_delay_ext = T_W'(i_delay);
    assign w_started   = (i_t >= w_delay_ext);
    // Subtract only once t has reached the delay, so r never wraps.
    assign w_r         = w_started ? (i_t - w_delay_ext) : '0;
    assign w_active    = i_en && w_started && (w_r < T_W'(BURST_L));
    assign w_phase     = w_r % T_W'(PERIOD);
    assign w_p_phase   = (w_phase < T_W'(HALF_PERIOD));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_p <= 1'b0;
            r_tx_n <= 1'b0;
        end else begin
            r_tx_p <= w_active && w_p_phase;
            r_tx_n <= w_active && !w_p_phase;
        end
    end

    assign o_tx_p = r_tx_p;
    assign o_tx_n = r_tx_n;

endmodule

// File: rtl/tx_fire_con.sv
// TX fire controller: loads per-channel delays over calc_start/calc_done, then fires delayed bursts.
// Burst lasts DMAX+BURST clk regardless of delays; calc latency is unbounded (waits on calc_done).
module tx_fire_con
    import tx_pkg::*;
#(
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int DELAY_WIDTH  = DELAY_WIDTH_DEF,
    parameter int HALF_PERIOD  = HALF_PERIOD_DEF,
    parameter int NUM_CYCLES   = NUM_CYCLES_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            fire,
    output logic                            calc_start,
    output logic [$clog2(NUM_CHANNELS)-1:0] calc_ch,
    input  logic                            calc_done,
    input  logic [DELAY_WIDTH-1:0]          calc_delay,
    output logic                            armed,
    output logic                            busy,
    output logic [NUM_CHANNELS-1:0]         tx_p,
    output logic [NUM_CHANNELS-1:0]         tx_n,
    output logic                            done
);

    localparam int CH_W    = $clog2(NUM_CHANNELS);
    localparam int BURST_L = burst_len(HALF_PERIOD, NUM_CYCLES);
    localparam int DMAX_L  = dmax_of(DELAY_WIDTH);
    localparam int T_W     = t_width(DELAY_WIDTH, HALF_PERIOD, NUM_CYCLES);

    localparam logic [T_W-1:0]  T_LAST  = T_W'(DMAX_L + BURST_L - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CHANNELS - 1);

    state_t                 r_state;
    logic [CH_W-1:0]        r_ch;
    logic [T_W-1:0]         r_t;
    logic [DELAY_WIDTH-1:0] r_delay [NUM_CHANNELS];

    logic                    w_fire_en;
    logic [NUM_CHANNELS-1:0] w_tx_p;
    logic [NUM_CHANNELS-1:0] w_tx_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_t     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_REQ;
                        r_ch    <= '0;
                    end
                end
                S_REQ: r_state <= S_WAIT;
                S_WAIT: begin
                    if (calc_done) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_ch == CH_LAST) begin
                        r_state <= S_ARMED;
                    end else begin
                        r_ch    <= r_ch + CH_W'(1);
                        r_state <= S_REQ;
                    end
                end
                S_ARMED: begin
                    // A reload request outranks a simultaneous fire.
                    if (start) begin
                        r_state <= S_REQ;
                        r_ch    <= '0;
                    end else if (fire) begin
                        r_state <= S_FIRE;
                        r_t     <= '0;
                    end
                end
                S_FIRE: begin
                    r_t <= r_t + T_W'(1);
                    if (r_t == T_LAST) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN:   r_state <= S_ARMED;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Delays survive bursts so the same focus can be re-fired without reloading.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_delay[i] <= '0;
            end
        end else if ((r_state == S_WAIT) && calc_done) begin
            r_delay[r_ch] <= calc_delay;
        end
    end

    assign w_fire_en = (r_state == S_FIRE);

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        tx_pulse_gen #(
            .DELAY_WIDTH (DELAY_WIDTH),
            .HALF_PERIOD (HALF_PERIOD),
            .NUM_CYCLES  (NUM_CYCLES),
            .T_W         (T_W)
        ) u_pulse_gen (
            .clk     (clk),
            .reset   (reset),
            .i_en    (w_fire_en),
            .i_t     (r_t),
            .i_delay (r_delay[g]),
            .o_tx_p  (w_tx_p[g]),
            .o_tx_n  (w_tx_n[g])
        );
    end

    assign calc_start = (r_state == S_REQ);
    assign calc_ch    = r_ch;
    assign armed      = (r_state == S_ARMED);
    assign busy       = (r_state == S_REQ)  || (r_state == S_WAIT) || (r_state == S_NEXT) ||
                        (r_state == S_FIRE) || (r_state == S_FIN);
    assign done       = (r_state == S_FIN);
    assign tx_p       = w_tx_p;
    assign tx_n       = w_tx_n;

endmodule

// File: tb/tb_tx_fire_con.sv
// Bench for tx_fire_con: scripted delay loads, burst waveforms against a cycle-indexed reference model.
module tb_tx_fire_con;

    localparam int NCH   = 16;
    localparam int DW    = 8;
    localparam int HP    = 4;
    localparam int NCY   = 2;
    localparam int BURST = 2 * HP * NCY;
    localparam int DMAX  = (1 << DW) - 1;
    localparam int FIRE_CYC = DMAX + BURST;       // cycles spent in FIRE
    localparam int DONE_K   = FIRE_CYC + 1;       // cycle index (after fire edge) showing done

    logic           clk;
    logic           reset;
    logic           start;
    logic           fire;
    logic           calc_start;
    logic [3:0]     calc_ch;
    logic           calc_done;
    logic [DW-1:0]  calc_delay;
    logic           armed;
    logic           busy;
    logic [NCH-1:0] tx_p;
    logic [NCH-1:0] tx_n;
    logic           done;

    tx_fire_con #(
        .NUM_CHANNELS (NCH),
        .DELAY_WIDTH  (DW),
        .HALF_PERIOD  (HP),
        .NUM_CYCLES   (NCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fire       (fire),
        .calc_start (calc_start),
        .calc_ch    (calc_ch),
        .calc_done  (calc_done),
        .calc_delay (calc_delay),
        .armed      (armed),
        .busy       (busy),
        .tx_p       (tx_p),
        .tx_n       (tx_n),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int start_pulses = 0;

    int mdl_delay [NCH];
    logic [NCH-1:0] cap_p [0:300];
    logic [NCH-1:0] cap_n [0:300];

    typedef struct {
        int   cyc;
        int   ch;
        logic ep;
        logic en;
    } vec_t;
    vec_t vt [17];

    always @(posedge clk) begin
        if (calc_start === 1'b1) start_pulses++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Expected pins k cycles after the edge that sampled fire: pins show t = k-2.
    function automatic void model(input int k, output logic [NCH-1:0] p, output logic [NCH-1:0] n);
        int tt;
        int r;
        p  = '0;
        n  = '0;
        tt = k - 2;
        if (tt >= 0 && tt < FIRE_CYC) begin
            for (int ch = 0; ch < NCH; ch++) begin
                r = tt - mdl_delay[ch];
                if (r >= 0 && r < BURST) begin
                    if (((r / HP) % 2) == 0) p[ch] = 1'b1;
                    else                     n[ch] = 1'b1;
                end
            end
        end
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Acts as the delay calculator; entered on the negedge where REQ is visible.
    task automatic load_all(input int lat, input int fire_ch);
        int n;
        int base;
        int stable_bad;
        base = start_pulses;
        stable_bad = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            n = 0;
            while (calc_start !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (calc_start !== 1'b1) begin
                chk($sformatf("calc_start_timeout_ch%0d", ch), 64'(calc_start), 64'(1));
                return;
            end
            chk($sformatf("calc_ch_order_%0d", ch), 64'(calc_ch), 64'(ch));
            for (int j = 1; j <= lat; j++) begin
                fire = (ch == fire_ch && j == 1);
                @(negedge clk);
                if (j == 1) chk($sformatf("calc_start_width_ch%0d", ch), 64'(calc_start), 64'(0));
                if (calc_ch !== 4'(ch)) stable_bad++;
            end
            fire       = 1'b0;
            calc_done  = 1'b1;
            calc_delay = DW'(mdl_delay[ch]);
            @(negedge clk);
            calc_done  = 1'b0;
            calc_delay = '0;
        end
        chk("calc_ch_stable", 64'(stable_bad), 64'(0));
        chk("armed_low_in_next", 64'(armed), 64'(0));
        chk("busy_in_next", 64'(busy), 64'(1));
        @(negedge clk);
        chk("armed_rise", 64'(armed), 64'(1));
        chk("busy_low_armed", 64'(busy), 64'(0));
        chk("calc_start_count", 64'(start_pulses - base), 64'(NCH));
    endtask

    // Fires from ARMED and compares every cycle of the burst with the model.
    task automatic run_burst(input string tag, input int start_cyc);
        int mism;
        int first_k;
        int overlap;
        int done_cnt;
        int done_k;
        int busy_bad;
        logic [NCH-1:0] ep;
        logic [NCH-1:0] en;
        mism = 0; first_k = -1; overlap = 0; done_cnt = 0; done_k = -1; busy_bad = 0;
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        for (int k = 1; k <= DONE_K + 2; k++) begin
            start = (k == start_cyc);
            model(k, ep, en);
            cap_p[k] = tx_p;
            cap_n[k] = tx_n;
            if (tx_p !== ep || tx_n !== en) begin
                if (mism == 0) first_k = k;
                mism++;
            end
            if ((tx_p & tx_n) != '0) overlap++;
            if (done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (busy !== (k <= DONE_K)) busy_bad++;
            @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("%s_wave_bad_cycles(first=%0d)", tag, first_k), 64'(mism), 64'(0));
        chk($sformatf("%s_p_n_overlap", tag), 64'(overlap), 64'(0));
        chk($sformatf("%s_done_count", tag), 64'(done_cnt), 64'(1));
        chk($sformatf("%s_done_cycle", tag), 64'(done_k), 64'(DONE_K));
        chk($sformatf("%s_busy_profile", tag), 64'(busy_bad), 64'(0));
        chk($sformatf("%s_armed_after", tag), 64'(armed), 64'(1));
    endtask

    initial begin
        int base;
        int bad_tx;
        int bad_busy;
        logic [NCH-1:0] ep;
        logic [NCH-1:0] en;

        // delay 0 on ch0, delay 10 on ch1: 4 high / 4 low, twice
        vt[0]  = '{1,   0, 1'b0, 1'b0};
        vt[1]  = '{2,   0, 1'b1, 1'b0};
        vt[2]  = '{5,   0, 1'b1, 1'b0};
        vt[3]  = '{6,   0, 1'b0, 1'b1};
        vt[4]  = '{9,   0, 1'b0, 1'b1};
        vt[5]  = '{10,  0, 1'b1, 1'b0};
        vt[6]  = '{14,  0, 1'b0, 1'b1};
        vt[7]  = '{17,  0, 1'b0, 1'b1};
        vt[8]  = '{18,  0, 1'b0, 1'b0};
        vt[9]  = '{11,  1, 1'b0, 1'b0};
        vt[10] = '{12,  1, 1'b1, 1'b0};
        vt[11] = '{15,  1, 1'b1, 1'b0};
        vt[12] = '{16,  1, 1'b0, 1'b1};
        vt[13] = '{20,  1, 1'b1, 1'b0};
        vt[14] = '{27,  1, 1'b0, 1'b1};
        vt[15] = '{28,  1, 1'b0, 1'b0};
        vt[16] = '{272, 15, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; fire = 1'b0; calc_done = 1'b0; calc_delay = '0;
        repeat (3) @(negedge clk);
        chk("rst_calc_start", 64'(calc_start), 64'(0));
        chk("rst_calc_ch", 64'(calc_ch), 64'(0));
        chk("rst_armed", 64'(armed), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_tx_p", 64'(tx_p), 64'(0));
        chk("rst_tx_n", 64'(tx_n), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        @(negedge clk);
        chk("idle_fire_ignored_busy", 64'(busy), 64'(0));
        chk("idle_fire_ignored_tx", 64'({tx_p, tx_n}), 64'(0));

        // Load 3*ch with 5-cycle calculator latency; fire poked during a WAIT.
        for (int ch = 0; ch < NCH; ch++) mdl_delay[ch] = 3 * ch;
        pulse_start();
        load_all(5, 3);
        run_burst("burst_3ch", -1);

        // start+fire together: reload wins, no burst.
        for (int ch = 0; ch < NCH; ch++) mdl_delay[ch] = int'($urandom_range(0, DMAX));
        mdl_delay[0]  = 0;
        mdl_delay[1]  = 10;
        mdl_delay[15] = DMAX;
        start = 1'b1; fire = 1'b1;
        @(negedge clk);
        start = 1'b0; fire = 1'b0;
        chk("prio_req_entered", 64'(calc_start), 64'(1));
        chk("prio_armed_drop", 64'(armed), 64'(0));
        chk("prio_no_tx", 64'({tx_p, tx_n}), 64'(0));
        load_all(2, -1);

        base = start_pulses;
        run_burst("burst_tab", 50);
        chk("start_in_fire_ignored", 64'(start_pulses - base), 64'(0));
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("vec%0d_tx_p(cyc%0d,ch%0d)", i, vt[i].cyc, vt[i].ch),
                64'(cap_p[vt[i].cyc][vt[i].ch]), 64'(vt[i].ep));
            chk($sformatf("vec%0d_tx_n(cyc%0d,ch%0d)", i, vt[i].cyc, vt[i].ch),
                64'(cap_n[vt[i].cyc][vt[i].ch]), 64'(vt[i].en));
        end

        // Stray calc_done while armed must not disturb stored delays.
        calc_done = 1'b1; calc_delay = 8'hAB;
        @(negedge clk);
        calc_done = 1'b0; calc_delay = '0;
        chk("spurious_done_armed", 64'(armed), 64'(1));
        run_burst("refire_1", -1);
        run_burst("refire_2", -1);

        for (int r = 0; r < 3; r++) begin
            for (int ch = 0; ch < NCH; ch++) mdl_delay[ch] = int'($urandom_range(0, DMAX));
            pulse_start();
            load_all(int'($urandom_range(1, 8)), -1);
            run_burst($sformatf("rand%0d_a", r), -1);
            run_burst($sformatf("rand%0d_b", r), int'($urandom_range(3, 200)));
        end

        // Reset at t=50 of a burst.
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        repeat (50) @(negedge clk);
        model(51, ep, en);
        chk("pre_reset_tx_p", 64'(tx_p), 64'(ep));
        chk("pre_reset_tx_n", 64'(tx_n), 64'(en));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx_p", 64'(tx_p), 64'(0));
        chk("midrst_tx_n", 64'(tx_n), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_armed", 64'(armed), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        bad_tx = 0;
        bad_busy = 0;
        for (int k = 0; k < 300; k++) begin
            if ((tx_p | tx_n) != '0) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            @(negedge clk);
        end
        chk("post_reset_fire_no_tx", 64'(bad_tx), 64'(0));
        chk("post_reset_fire_not_busy", 64'(bad_busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
